// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// Each access takes three cycles: sample (IDLE), memory strobe (ACCESS) and
// response (RESP). Requester 0 is the CPU data port, requester 1 the DMA/loader.
// Build option: define DMEM_ARB_RR_EN for round-robin on simultaneous requests;
// without it requester 0 always wins ties.
module dmem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e        state_q, state_d;
   logic          win_q, win_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          sel;

   // Pick the requester that would win if the arbiter samples this cycle
   always_comb begin
      sel = 1'b0;
      if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
         sel = ~last_q;
`else
         sel = 1'b0;
`endif
      end else if (m1_req) begin
         sel = 1'b1;
      end
   end

   // Next-state logic: latch the winner's request in IDLE, capture read data leaving ACCESS
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               state_d = ACCESS;
               win_d   = sel;
               we_d    = sel ? m1_we    : m0_we;
               addr_d  = sel ? m1_addr  : m0_addr;
               wdata_d = sel ? m1_wdata : m0_wdata;
            end
         end
         ACCESS: begin
            state_d = RESP;
            rdata_d = mem_rdata;
            last_d  = win_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode: strobes and grant only in ACCESS, response only in RESP
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == ACCESS) begin
         m0_gnt    = ~win_q;
         m1_gnt    = win_q;
         mem_re    = ~we_q;
         mem_we    = we_q;
         mem_addr  = addr_q;
         mem_wdata = wdata_q;
      end
      if (state_q == RESP) begin
         m0_rvalid = ~win_q;
         m1_rvalid = win_q;
         if (!we_q) begin
            if (win_q) m1_rdata = rdata_q;
            else       m0_rdata = rdata_q;
         end
      end
   end

   // Control state with asynchronous reset; last winner resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         win_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         last_q  <= last_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   // Request payload; only observed while ACCESS, so no reset is needed
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed bench for dmem_arbiter with a
// transaction-level reference model (schedule of the one in-flight access plus
// a reference memory array). Honors DMEM_ARB_RR_EN the same way as the design.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0;
   logic        m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m1_addr = '0, m1_wdata = '0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_re, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] dmem    [64] = '{4: 32'hDEADBEEF, default: 32'h0};
   logic [31:0] ref_mem [64] = '{4: 32'hDEADBEEF, default: 32'h0};

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Bench DMEM: combinational read, write on the rising edge
   assign mem_rdata = dmem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int n_gnt = 0, n_rv = 0;

   // Reference model: at most one access in flight
   bit          rec_v = 1'b0;
   int          rec_cyc = 0;
   bit          rec_id = 1'b0, rec_we = 1'b0;
   logic [31:0] rec_addr = '0, rec_wdata = '0, rec_rdata = '0;
   bit          last_w = 1'b1;
   int          free_edge = 0;
   bit          acc_flag [2] = '{1'b0, 1'b0};
   bit          pend [2] = '{1'b0, 1'b0};
   int          acc_total = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   // Model at a rising edge (edge number = cyc)
   task automatic model_edge();
      bit id;
      if (!rst_n) return;
      if (rec_v && rec_cyc == cyc - 1) begin
         last_w = rec_id;
         if (rec_we) ref_mem[rec_addr[7:2]] = rec_wdata;
         else        rec_rdata = ref_mem[rec_addr[7:2]];
      end
      if (cyc >= free_edge && (m0_req || m1_req)) begin
         if (m0_req && m1_req) begin
`ifdef DMEM_ARB_RR_EN
            id = ~last_w;
`else
            id = 1'b0;
`endif
         end else begin
            id = m1_req;
         end
         rec_v     = 1'b1;
         rec_cyc   = cyc;
         rec_id    = id;
         rec_we    = id ? m1_we    : m0_we;
         rec_addr  = id ? m1_addr  : m0_addr;
         rec_wdata = id ? m1_wdata : m0_wdata;
         free_edge = cyc + 3;
         acc_flag[id] = 1'b1;
         acc_total++;
      end
   endtask

   task automatic model_reset();
      rec_v = 1'b0;
      last_w = 1'b1;
      free_edge = cyc + 1;
      acc_flag[0] = 1'b0;
      acc_flag[1] = 1'b0;
   endtask

   // Per-cycle compare of every DUT output against the model schedule
   task automatic cmp_cycle();
      bit g, r;
      logic [5:0] exp_ctl;
      g = rec_v && (rec_cyc == cyc);
      r = rec_v && (rec_cyc + 1 == cyc);
      exp_ctl = {g && !rec_id, g && rec_id, r && !rec_id, r && rec_id, g && !rec_we, g && rec_we};
      check("ctl", {58'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_re, mem_we}, {58'd0, exp_ctl});
      check("m0_rdata", m0_rdata, (r && !rec_id && !rec_we) ? rec_rdata : 32'h0);
      check("m1_rdata", m1_rdata, (r &&  rec_id && !rec_we) ? rec_rdata : 32'h0);
      check("re_we_excl", mem_re & mem_we, 0);
      if (g) begin
         check("mem_addr", mem_addr, rec_addr);
         check("mem_wdata", mem_wdata, rec_wdata);
      end
      n_gnt += int'(m0_gnt) + int'(m1_gnt);
      n_rv  += int'(m0_rvalid) + int'(m1_rvalid);
   endtask

   task automatic tick();
      @(negedge clk);
      cmp_cycle();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic set_m(input int i, input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
      if (i == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
      else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
   endtask

   task automatic drive_rand();
      for (int i = 0; i < 2; i++) begin
         if (acc_flag[i]) begin
            acc_flag[i] = 1'b0;
            pend[i] = 1'b0;
         end else if (pend[i]) begin
            if ($urandom_range(0, 31) == 0) begin
               set_m(i, 1'b0, 1'b0, 32'h0, 32'h0);
               pend[i] = 1'b0;
            end
         end else if ($urandom_range(0, 3) != 0) begin
            set_m(i, 1'b1, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            pend[i] = 1'b1;
         end else begin
            set_m(i, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
   endtask

   int gq_id [$];
   int gq_cyc [$];

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("reset_outputs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_re, mem_we}, 0);
      check("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
      check("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
      set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // m0 read of a preloaded word
      tick();
      check("rd_m0_gnt", {m0_gnt, m1_gnt}, 2'b10);
      check("rd_mem_re", {mem_re, mem_we}, 2'b10);
      check("rd_mem_addr", mem_addr, 32'h10);
      tick();
      check("rd_m0_rvalid", m0_rvalid, 1);
      check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // m1 write, then m0 reads it back
      set_m(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
      tick();
      check("wr_m1_gnt", {m0_gnt, m1_gnt}, 2'b01);
      check("wr_mem_we", {mem_re, mem_we}, 2'b01);
      check("wr_addr_data", {mem_addr, mem_wdata}, {32'h20, 32'h12345678});
      tick();
      check("wr_m1_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
      check("wr_m1_rdata", m1_rdata, 32'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      set_m(0, 1'b1, 1'b0, 32'h20, 32'h0);
      tick();
      tick();
      check("rdback_rdata", m0_rdata, 32'h12345678);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Both requesters held continuously after a reset
      rst_n = 1'b0;
      #1 model_reset();
      rst_n = 1'b1;
      set_m(0, 1'b1, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b1, 1'b0, 32'h4, 32'h0);
      for (int k = 0; k < 12; k++) begin
         tick();
         if (m0_gnt) begin gq_id.push_back(0); gq_cyc.push_back(cyc); end
         if (m1_gnt) begin gq_id.push_back(1); gq_cyc.push_back(cyc); end
      end
      check("both_gnt_count", gq_id.size(), 4);
      for (int k = 0; k < gq_id.size() && k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         check("both_gnt_order", gq_id[k], k % 2);
`else
         check("both_gnt_order", gq_id[k], 0);
`endif
         if (k > 0) check("both_gnt_spacing", gq_cyc[k] - gq_cyc[k-1], 3);
      end
      if (gq_id.size() > 0) check("model_last_winner", last_w, gq_id[gq_id.size()-1]);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) tick();

      // Reset pulse in the ACCESS cycle of a write
      set_m(1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
      tick();
      check("abort_we_before", mem_we, 1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_we_dropped", {m0_gnt, m1_gnt, mem_re, mem_we}, 0);
      model_reset();
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 rst_n = 1'b1;
      repeat (3) begin
         tick();
         check("abort_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
      end
      set_m(0, 1'b1, 1'b0, 32'h30, 32'h0);
      tick();
      check("abort_idle_gnt", m0_gnt, 1);
      tick();
      check("abort_not_written", m0_rdata, 32'h0);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // Random traffic on both ports
      n_gnt = 0;
      n_rv = 0;
      acc_total = 0;
      acc_flag[0] = 1'b0;
      acc_flag[1] = 1'b0;
      while (acc_total < 10000 && cyc < 80000) begin
         drive_rand();
         tick();
      end
      check("random_accesses_done", acc_total >= 10000, 1);
      set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) tick();
      check("gnt_eq_rvalid", n_gnt, n_rv);
      check("gnt_eq_model", n_gnt, acc_total);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, byte-address width of all address ports.
REQ-002 Parameter DW, default 32, data width of all data ports.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req  input  1  requester 0 (CPU data port) access request.
REQ-006 m0_we  input  1  requester 0 write (1) / read (0).
REQ-007 m0_addr  input  AW  requester 0 address.
REQ-008 m0_wdata  input  DW  requester 0 write data.
REQ-009 m0_gnt  output  1  one-cycle pulse: requester 0 request accepted.
REQ-010 m0_rvalid  output  1  one-cycle pulse: requester 0 access complete.
REQ-011 m0_rdata  output  DW  requester 0 read data, valid with m0_rvalid.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings as m0_*, for requester 1 (DMA/loader port).
REQ-013 mem_re  output  1  DMEM read enable.
REQ-014 mem_we  output  1  DMEM write enable.
REQ-015 mem_addr  output  AW  DMEM address.
REQ-016 mem_wdata  output  DW  DMEM write data.
REQ-017 mem_rdata  input  DW  DMEM combinational read data.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when m0_req|m1_req, ACCESS->RESP always, RESP->IDLE always.
REQ-019 In IDLE with any request, winner is selected, its we/addr/wdata are registered into mem_* and its id into a winner register.
REQ-020 In ACCESS: winner's mx_gnt = 1, mem_re = !we, mem_we = we, mem_addr/mem_wdata = registered values; mem_rdata captured on the edge leaving ACCESS.
REQ-021 In RESP: winner's mx_rvalid = 1; mx_rdata = captured data for reads, 0 for writes; loser's rvalid = 0.
REQ-022 Latency: request sampled at edge N -> gnt and memory strobe in cycle N+1 -> rvalid in cycle N+2; one access per 3 cycles max.
REQ-023 Requesters hold req/we/addr/wdata stable until gnt; req may drop or be re-asserted in the cycle after gnt; requests are not sampled in ACCESS or RESP.
REQ-024 mem_re, mem_we, all gnt and rvalid outputs are 0 in IDLE and in any state except as stated above; mem_re and mem_we are never both 1.
REQ-025 Non-winning mx_rdata outputs are 0.
REQ-026 Last-winner register updates to the winner on entry to RESP.
REQ-027 Request dropped before being sampled: no grant, no memory strobe.

Reset
REQ-028 rst_n low forces state IDLE, winner = 0, last-winner = 1 (so requester 0 wins first tie), captured data = 0, all outputs 0, immediately and asynchronously.
REQ-029 Reset asserted in ACCESS or RESP aborts the access: no rvalid issued for it after release; an in-progress mem_we is dropped in the same cycle.
REQ-030 First request sampled at the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro DMEM_ARB_RR_EN defined: round-robin on simultaneous requests -- requester other than last-winner wins.
REQ-032 Macro DMEM_ARB_RR_EN undefined: fixed priority, m0 always wins ties; last-winner register still updates but does not affect selection.
REQ-033 Single requests win immediately in both modes.

Verification
REQ-034 Reset, m0 read addr 0x10, DMEM[0x10]=0xDEADBEEF -> m0_gnt cycle 1, mem_re=1 mem_addr=0x10 cycle 1, m0_rvalid with m0_rdata=0xDEADBEEF cycle 2.
REQ-035 m1 write addr 0x20 data 0x12345678 -> mem_we=1 with those values one cycle, m1_rvalid cycle after with m1_rdata=0; later m0 read 0x20 returns 0x12345678.
REQ-036 m0 and m1 held requesting continuously, RR_EN defined -> grants alternate m0,m1,m0,m1 at 3-cycle spacing.
REQ-037 Same stimulus, RR_EN undefined -> every grant to m0, m1 never granted.
REQ-038 rst_n pulsed low during ACCESS of a write -> mem_we drops that cycle, no rvalid after release, state IDLE.
REQ-039 Random traffic, both ports, 10k accesses -> never mem_re&mem_we, exactly one rvalid per gnt, read data matches reference memory model.
